// File: rtl/rank_sched_pkg.sv
// Shared definitions for the rank scheduler: command/data widths, rank field
// position, FSM encoding and the captured-request record.
package rank_sched_pkg;

    localparam int CMD_W    = 34;
    localparam int DATA_W   = 128;
    localparam int RANK_MSB = 33;
    localparam int RANK_LSB = 32;
    localparam int RANK_W   = RANK_MSB - RANK_LSB + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT_RD = 2'd2;
    localparam logic [1:0] S_GAP     = 2'd3;

    typedef struct packed {
        logic              rw;
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic logic [RANK_W-1:0] rank_of(input logic [CMD_W-1:0] cmd);
        return cmd[RANK_MSB:RANK_LSB];
    endfunction

endpackage

// File: rtl/rank_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester found when
// searching upward from last_i+1, wrapping at NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] last_i,
    output logic [NREQ-1:0] grant_o
);

    always_comb begin
        int          pos;
        logic [ID_W-1:0] idx;
        logic        found;
        grant_o = '0;
        found   = 1'b0;
        pos     = 0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = (int'(last_i) + k) % NREQ;
            idx = ID_W'(pos);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rank_sched.sv
// Multi-requester scheduler in front of a ranked Package: arbitrates, issues
// one command at a time and routes read data back to the owning requester.
module rank_sched
    import rank_sched_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int WR_GAP     = 4,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     i_power_on_rst_n,
    input  logic [NREQ-1:0]          i_req_valid,
    output logic [NREQ-1:0]          o_req_ready,
    input  logic [NREQ*CMD_W-1:0]    i_req_cmd,
    input  logic [NREQ-1:0]          i_req_rw,
    input  logic [NREQ*DATA_W-1:0]   i_req_wdata,
    output logic [NREQ-1:0]          o_rsp_valid,
    output logic [DATA_W-1:0]        o_rsp_data,
    output logic [CMD_W-1:0]         o_pkg_command,
    output logic [DATA_W-1:0]        o_pkg_write_data,
    output logic                     o_pkg_valid,
    input  logic [DATA_W-1:0]        i_pkg_read_data,
    input  logic                     i_pkg_read_data_valid,
    output logic                     o_err_timeout
);

    localparam int ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_MAX = (RD_TIMEOUT > WR_GAP) ? RD_TIMEOUT : WR_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NREQ - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(WR_GAP - 1);
    localparam logic [CNT_W-1:0] TMO_END  = CNT_W'(RD_TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   id_q, id_d;
    req_t              req_q, req_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   arb_req;
    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   grant_id;
    req_t              req_slice [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign req_slice[gi] = '{rw:    i_req_rw[gi],
                                     cmd:   i_req_cmd[gi*CMD_W +: CMD_W],
                                     wdata: i_req_wdata[gi*DATA_W +: DATA_W]};
        end
    endgenerate

    assign arb_req = i_req_valid & {NREQ{state_q == S_IDLE}};

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req_i   (arb_req),
        .last_i  (last_q),
        .grant_o (grant)
    );

    always_comb begin
        grant_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) grant_id = ID_W'(k);
        end
    end

    // The grant is combinational on the request inputs, so it is also gated
    // by the reset pin to keep every output low while reset is held.
    assign o_req_ready = grant & {NREQ{i_power_on_rst_n}};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        id_d        = id_q;
        req_d       = req_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    req_d   = req_slice[grant_id];
                    id_d    = grant_id;
                    last_d  = grant_id;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = req_q.rw ? S_WAIT_RD : S_GAP;
            end
            S_GAP: begin
                if (cnt_q == GAP_END) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_RD: begin
                if (i_pkg_read_data_valid) begin
                    rsp_data_d        = i_pkg_read_data;
                    rsp_valid_d[id_q] = 1'b1;
                    cnt_d             = '0;
                    state_d           = S_IDLE;
                end else if (cnt_q == TMO_END) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_power_on_rst_n) begin
        if (!i_power_on_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_q      <= LAST_RST;
            id_q        <= '0;
            req_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            id_q        <= id_d;
            req_q       <= req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    // The whole command is held after issue so the rank field keeps steering
    // the Package read-data mux until the next command goes out.
    assign o_pkg_valid      = (state_q == S_ISSUE);
    assign o_pkg_command    = req_q.cmd;
    assign o_pkg_write_data = req_q.wdata;
    assign o_rsp_valid      = rsp_valid_q;
    assign o_rsp_data       = rsp_data_q;
    assign o_err_timeout    = err_q;

endmodule

// File: tb/tb_rank_sched.sv
// Randomized bench for rank_sched, checked cycle by cycle against a
// transaction-level timing model of grants, issues, responses and timeouts.
module tb_rank_sched;
    import rank_sched_pkg::*;

    localparam int NREQ       = 4;
    localparam int WR_GAP     = 4;
    localparam int RD_TIMEOUT = 255;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*CMD_W-1:0]  req_cmd;
    logic [NREQ-1:0]        req_rw;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic [CMD_W-1:0]       pkg_cmd;
    logic [DATA_W-1:0]      pkg_wdata;
    logic                   pkg_valid;
    logic [DATA_W-1:0]      pkg_rdata;
    logic                   pkg_rvalid;
    logic                   err_tmo;

    always #5 clk = ~clk;

    rank_sched #(
        .NREQ       (NREQ),
        .WR_GAP     (WR_GAP),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) dut (
        .clk                   (clk),
        .i_power_on_rst_n      (rst_n),
        .i_req_valid           (req_valid),
        .o_req_ready           (req_ready),
        .i_req_cmd             (req_cmd),
        .i_req_rw              (req_rw),
        .i_req_wdata           (req_wdata),
        .o_rsp_valid           (rsp_valid),
        .o_rsp_data            (rsp_data),
        .o_pkg_command         (pkg_cmd),
        .o_pkg_write_data      (pkg_wdata),
        .o_pkg_valid           (pkg_valid),
        .i_pkg_read_data       (pkg_rdata),
        .i_pkg_read_data_valid (pkg_rvalid),
        .o_err_timeout         (err_tmo)
    );

    int vec_cnt    = 0;
    int miscmp_cnt = 0;
    int cyc        = 0;

    // stimulus knobs
    logic            rst_drive;
    logic [NREQ-1:0] active;
    int  valid_pct, cancel_pct, rd_pct, stray_pct, tmo_pct, lat_mode;
    bit  refill, a5;
    bit              pend_v  [NREQ];
    logic            pend_rw [NREQ];
    logic [CMD_W-1:0] pend_cmd [NREQ];

    // reference model state
    int  free_cyc, last_g, issue_cyc, rd_id, rd_data_cyc, rsp_cyc, tmo_cyc;
    int  granted_k;
    bit  rd_inflight;
    logic [CMD_W-1:0]  iss_cmd;
    logic [DATA_W-1:0] iss_wd, exp_rsp;
    logic [1:0]        exp_rank;
    int  g_id_q[$];
    int  g_cyc_q[$];

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s at cycle %0d: got %h, want %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        free_cyc    = cyc;
        last_g      = NREQ - 1;
        issue_cyc   = -1;
        rd_data_cyc = -1;
        rsp_cyc     = -1;
        tmo_cyc     = -1;
        rd_inflight = 1'b0;
        exp_rank    = 2'b00;
        granted_k   = -1;
    endtask

    task automatic load_req(input int k, input logic rw, input logic [CMD_W-1:0] cmd);
        req_valid[k]                 = 1'b1;
        req_rw[k]                    = rw;
        req_cmd[k*CMD_W +: CMD_W]    = cmd;
        req_wdata[k*DATA_W +: DATA_W] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic post(input int k, input logic rw, input logic [CMD_W-1:0] cmd);
        pend_v[k]   = 1'b1;
        pend_rw[k]  = rw;
        pend_cmd[k] = cmd;
    endtask

    function automatic int pick_lat();
        if (lat_mode != 0) return lat_mode;
        if (int'($urandom_range(99)) < tmo_pct) return -1;
        return int'($urandom_range(6, 1));
    endfunction

    task automatic evaluate();
        logic [NREQ-1:0] er;
        logic [NREQ-1:0] ersp;
        int eid, lat;
        if (!rst_n) begin
            chk("rst_ready", DATA_W'(req_ready), '0);
            chk("rst_rsp_valid", DATA_W'(rsp_valid), '0);
            chk("rst_rsp_data", rsp_data, '0);
            chk("rst_pkg_cmd", DATA_W'(pkg_cmd), '0);
            chk("rst_pkg_wdata", pkg_wdata, '0);
            chk("rst_pkg_valid", DATA_W'(pkg_valid), '0);
            chk("rst_timeout", DATA_W'(err_tmo), '0);
            return;
        end
        // Package side
        if (cyc == issue_cyc) exp_rank = iss_cmd[RANK_MSB:RANK_LSB];
        chk("pkg_valid", DATA_W'(pkg_valid), DATA_W'(cyc == issue_cyc));
        chk("rank", DATA_W'(pkg_cmd[RANK_MSB:RANK_LSB]), DATA_W'(exp_rank));
        if (cyc == issue_cyc) begin
            chk("pkg_cmd", DATA_W'(pkg_cmd), DATA_W'(iss_cmd));
            chk("pkg_wdata", pkg_wdata, iss_wd);
        end
        // responses and timeouts
        ersp = '0;
        if (cyc == rsp_cyc) ersp[rd_id] = 1'b1;
        chk("rsp_valid", DATA_W'(rsp_valid), DATA_W'(ersp));
        if (cyc == rsp_cyc) begin
            chk("rsp_data", rsp_data, exp_rsp);
            rd_inflight = 1'b0;
            $display("txn cyc=%0d read done req%0d data=%h", cyc, rd_id, exp_rsp);
        end
        chk("timeout", DATA_W'(err_tmo), DATA_W'(cyc == tmo_cyc));
        if (cyc == tmo_cyc) begin
            rd_inflight = 1'b0;
            $display("txn cyc=%0d read timeout req%0d", cyc, rd_id);
        end
        // arbitration
        er  = '0;
        eid = -1;
        if (cyc >= free_cyc) begin
            for (int j = 1; j <= NREQ; j++) begin
                int k;
                k = (last_g + j) % NREQ;
                if (eid < 0 && req_valid[k]) eid = k;
            end
        end
        if (eid >= 0) er[eid] = 1'b1;
        chk("ready", DATA_W'(req_ready), DATA_W'(er));
        for (int k = 0; k < NREQ; k++) begin
            if (req_ready[k]) begin
                g_id_q.push_back(k);
                g_cyc_q.push_back(cyc);
            end
        end
        if (eid >= 0) begin
            granted_k = eid;
            last_g    = eid;
            issue_cyc = cyc + 1;
            iss_cmd   = req_cmd[eid*CMD_W +: CMD_W];
            iss_wd    = req_wdata[eid*DATA_W +: DATA_W];
            $display("txn cyc=%0d grant req%0d %s cmd=%h", cyc, eid,
                     req_rw[eid] ? "RD" : "WR", iss_cmd);
            if (!req_rw[eid]) begin
                free_cyc = cyc + 2 + WR_GAP;
            end else begin
                rd_inflight = 1'b1;
                rd_id       = eid;
                lat         = pick_lat();
                if (lat < 0) begin
                    rd_data_cyc = -1;
                    rsp_cyc     = -1;
                    tmo_cyc     = cyc + 2 + RD_TIMEOUT;
                    free_cyc    = tmo_cyc;
                end else begin
                    tmo_cyc     = -1;
                    rd_data_cyc = cyc + 1 + lat;
                    rsp_cyc     = rd_data_cyc + 1;
                    free_cyc    = rsp_cyc;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rst_drive != rst_n) begin
            rst_n = rst_drive;
            model_reset();
        end
        for (int k = 0; k < NREQ; k++) begin
            if (granted_k == k) begin
                if (refill) load_req(k, 1'b0, {2'($urandom_range(3)), 32'($urandom)});
                else        req_valid[k] = 1'b0;
            end else if (pend_v[k]) begin
                load_req(k, pend_rw[k], pend_cmd[k]);
                pend_v[k] = 1'b0;
            end else if (!req_valid[k] && active[k] && int'($urandom_range(99)) < valid_pct) begin
                load_req(k, int'($urandom_range(99)) < rd_pct,
                         {2'($urandom_range(3)), 32'($urandom)});
            end else if (req_valid[k] && int'($urandom_range(99)) < cancel_pct) begin
                req_valid[k] = 1'b0;
            end
        end
        granted_k = -1;
        pkg_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (a5 && cyc == rd_data_cyc) pkg_rdata = {16{8'hA5}};
        pkg_rvalid = (cyc == rd_data_cyc) ||
                     (!rd_inflight && int'($urandom_range(99)) < stray_pct);
        if (cyc == rd_data_cyc) exp_rsp = pkg_rdata;
        @(negedge clk);
        evaluate();
    endtask

    initial begin
        int fair_exp[5];
        fair_exp = '{0, 1, 2, 3, 0};
        rst_n = 1'b1;
        rst_drive = 1'b0;
        req_valid = '0; req_rw = '0; req_cmd = '0; req_wdata = '0;
        pkg_rdata = '0; pkg_rvalid = 1'b0;
        for (int k = 0; k < NREQ; k++) pend_v[k] = 1'b0;
        active = '1; valid_pct = 100; cancel_pct = 0; rd_pct = 0;
        stray_pct = 0; tmo_pct = 0; lat_mode = 0; refill = 1'b1; a5 = 1'b0;
        iss_cmd = '0; iss_wd = '0; exp_rsp = '0; rd_id = 0;
        model_reset();
        #2 rst_n = 1'b0;

        // reset held with every requester valid
        repeat (4) step();
        g_id_q.delete();
        g_cyc_q.delete();
        rst_drive = 1'b1;
        step();
        chk("first_grant", DATA_W'(req_ready), DATA_W'(4'b0001));

        // fairness with continuous writes
        repeat (30) step();
        chk("fair_count", DATA_W'(g_id_q.size() >= 5), DATA_W'(1));
        for (int i = 0; i < 5 && i < g_id_q.size(); i++) begin
            chk("fair_id", DATA_W'(g_id_q[i]), DATA_W'(fair_exp[i]));
            if (i > 0) chk("fair_gap", DATA_W'(g_cyc_q[i] - g_cyc_q[i-1]), DATA_W'(6));
        end
        active = '0; refill = 1'b0;
        repeat (30) step();

        // directed read to rank 2 with A5 data three cycles after issue
        a5 = 1'b1; lat_mode = 3;
        post(2, 1'b1, {2'b10, 32'($urandom)});
        repeat (12) step();
        a5 = 1'b0;

        // timeout, then the waiting write is granted
        lat_mode = -1;
        post(3, 1'b1, {2'b01, 32'($urandom)});
        post(0, 1'b0, {2'b11, 32'($urandom)});
        repeat (270) step();

        // data on the last accepted wait cycle, and minimum latency
        lat_mode = 255;
        post(1, 1'b1, {2'b00, 32'($urandom)});
        repeat (265) step();
        lat_mode = 1;
        post(0, 1'b1, {2'b11, 32'($urandom)});
        repeat (6) step();

        // stray Package valids around writes
        lat_mode = 0; tmo_pct = 0; stray_pct = 50;
        active = '1; valid_pct = 50; rd_pct = 0;
        repeat (60) step();
        active = '0; stray_pct = 0;
        repeat (40) step();

        // reset in the middle of a read wait
        lat_mode = -1;
        post(1, 1'b1, {2'b10, 32'($urandom)});
        repeat (10) step();
        rst_drive = 1'b0;
        for (int k = 0; k < NREQ; k++) post(k, 1'b0, {2'($urandom_range(3)), 32'($urandom)});
        repeat (3) step();
        rst_drive = 1'b1;
        step();
        chk("rst_grant0", DATA_W'(req_ready), DATA_W'(4'b0001));
        repeat (300) step();

        // mixed random traffic
        lat_mode = 0; tmo_pct = 3; stray_pct = 10; active = '1;
        valid_pct = 30; cancel_pct = 5; rd_pct = 50;
        repeat (3000) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule

// File: doc/rank_sched.md
RANK_SCHED -- requirements
Module: rank_sched

Interface
REQ-001 Parameters: NREQ=4, requester count; CMD_W=34, Package command width ([33:32] rank select, [31:0] rank command); DATA_W=128, write/read data width (DQ_BITS*8); WR_GAP=4, idle cycles after a write issue; RD_TIMEOUT=255, maximum wait cycles for read data.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 i_power_on_rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_req_valid  in  NREQ  per-requester request valid.
REQ-005 o_req_ready  out  NREQ  per-requester accept; at most one bit high.
REQ-006 i_req_cmd  in  NREQ*CMD_W  per-requester command; slice k is requester k.
REQ-007 i_req_rw  in  NREQ  per-requester type: 1 = read, 0 = write.
REQ-008 i_req_wdata  in  NREQ*DATA_W  per-requester write data.
REQ-009 o_rsp_valid  out  NREQ  one-cycle read-response pulse to the owning requester.
REQ-010 o_rsp_data  out  DATA_W  read data, qualified by o_rsp_valid.
REQ-011 o_pkg_command  out  CMD_W  command to the Package.
REQ-012 o_pkg_write_data  out  DATA_W  write data to the Package.
REQ-013 o_pkg_valid  out  1  command strobe to the Package.
REQ-014 i_pkg_read_data  in  DATA_W  read data from the Package.
REQ-015 i_pkg_read_data_valid  in  1  read data valid from the Package.
REQ-016 o_err_timeout  out  1  one-cycle pulse when a read is abandoned.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT_RD and GAP.
REQ-018 IDLE: the block SHALL drive o_req_ready as a one-hot grant to the first valid requester, searching round-robin from last_grant+1; o_req_ready SHALL be 0 in every other state.
REQ-019 On valid&ready, the block SHALL register cmd, wdata, rw and requester id, SHALL set last_grant to that id, and SHALL go to ISSUE.
REQ-020 ISSUE: o_pkg_valid SHALL be 1 for exactly one cycle with the registered command and data; the next state SHALL be WAIT_RD for a read and GAP for a write.
REQ-021 o_pkg_command[33:32] SHALL hold the last issued rank in all states until the next ISSUE, because the Package read-data mux follows the rank field; o_pkg_valid SHALL be 0 outside ISSUE.
REQ-022 GAP: the block SHALL wait WR_GAP cycles, counting from the cycle after ISSUE, and then go to IDLE.
REQ-023 WAIT_RD, on i_pkg_read_data_valid: next cycle, o_rsp_data SHALL equal the captured i_pkg_read_data and o_rsp_valid[id] SHALL pulse; the state SHALL return to IDLE.
REQ-024 WAIT_RD timeout: if no valid arrives within RD_TIMEOUT cycles of entering WAIT_RD, o_err_timeout SHALL pulse once, no response SHALL be issued, and the state SHALL go to IDLE.
REQ-025 i_pkg_read_data_valid outside WAIT_RD SHALL be ignored.
REQ-026 Requesters SHALL hold valid, cmd, rw and wdata stable until ready; a drop of valid before ready SHALL cancel the request without side effect.
REQ-027 Minimum occupancy SHALL be 2+WR_GAP cycles per write and 3 cycles per read with 1-cycle data latency.

Reset
REQ-028 During reset: state=IDLE, last_grant=NREQ-1 (requester 0 first), and counters=0.
REQ-029 During reset, all outputs SHALL be 0, including o_pkg_command and o_pkg_write_data.
REQ-030 Reset asserted mid-operation SHALL drop the in-flight request with no response and no timeout pulse.

Structure
REQ-031 CMD_W, DATA_W, the rank-field position and the state encoding SHALL reside in the shared package.
REQ-032 The round-robin arbiter SHALL be a sub-module, rr_arbiter (request vector plus last_grant in, one-hot grant out).

Verification
REQ-033 Reset: hold i_power_on_rst_n low -> all outputs 0; first grant after release goes to requester 0.
REQ-034 Fairness: all four requesters continuously valid with writes -> grants in order 0,1,2,3,0; each grant is 6 cycles apart.
REQ-035 Read: requester 2 reads with cmd[33:32]=2'b10; Package returns 0xA5..A5 three cycles after o_pkg_valid -> o_rsp_valid=4'b0100 one cycle later with the same data; o_pkg_command[33:32]=2'b10 throughout.
REQ-036 Timeout: read issued with no i_pkg_read_data_valid -> o_err_timeout pulses 255 cycles after WAIT_RD entry; the next request is then granted.
REQ-037 Stray valid: i_pkg_read_data_valid pulses during GAP -> no o_rsp_valid.
REQ-038 Reset mid-WAIT_RD -> no response, no timeout pulse, and a grant to requester 0 after release.
